dmem_lsu: RTL and testbench

Load/store unit that initiates accesses on the data-memory port on behalf of the core pipeline. It accepts one RISC-V load or store request at a time and converts byte addresses to word addresses. Sub-word stores are done as read-modify-write, because the memory port has only a whole-word write enable. Load data is aligned and sign- or zero-extended before return. It sits between the execute/memory stage and the `dmem` word memory (synchronous read, 1-cycle latency, no byte enables).

---
 rtl/dmem_lsu.sv | 146 ++++++++++++++
 tb/tb_dmem_lsu.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_lsu.sv
// Load/store unit between the memory stage and a word-wide synchronous data memory.
// Handles one request at a time. Sub-word stores are done as read-modify-write.
module dmem_lsu #(
  parameter int N = 5
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic          req_we,
  input  logic [2:0]    req_funct3,
  input  logic [31:0]   req_addr,
  input  logic [31:0]   req_wdata,
  output logic          rsp_valid,
  output logic [31:0]   rsp_rdata,
  output logic          rsp_err,
  output logic          mem_we,
  output logic [N:0]    mem_addr,
  output logic [31:0]   mem_wdata,
  input  logic [31:0]   mem_rdata
);

  typedef enum logic [2:0] {IDLE, ACCESS, DATA, WRITE, RESP} state_t;

  state_t        state_q, state_d;
  logic          we_q, we_d;
  logic [2:0]    funct3_q, funct3_d;
  logic [1:0]    alo_q, alo_d;
  logic [15:0]   wdata_q, wdata_d;
  logic [N:0]    mem_addr_q, mem_addr_d;
  logic [31:0]   mem_wdata_q, mem_wdata_d;
  logic [31:0]   rsp_rdata_q, rsp_rdata_d;
  logic          rsp_err_q, rsp_err_d;

  function automatic logic req_bad(input logic we, input logic [2:0] f3,
                                   input logic [31:0] a);
    logic illegal, misal, oor;
    illegal = we ? (f3 >= 3'b011)
                 : (f3 == 3'b011 || f3 == 3'b110 || f3 == 3'b111);
    misal   = (f3[1:0] == 2'b01 && a[0]) || (f3[1:0] == 2'b10 && a[1:0] != 2'b00);
    oor     = (a >> (N + 3)) != 32'd0;
    return illegal || misal || oor;
  endfunction

  function automatic logic [31:0] load_fmt(input logic [2:0] f3, input logic [1:0] a,
                                           input logic [31:0] w);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    b = w[{a, 3'b000} +: 8];
    h = a[1] ? w[31:16] : w[15:0];
    case (f3)
      3'b000:  r = {{24{b[7]}}, b};
      3'b100:  r = {24'd0, b};
      3'b001:  r = {{16{h[15]}}, h};
      3'b101:  r = {16'd0, h};
      default: r = w;
    endcase
    return r;
  endfunction

  function automatic logic [31:0] store_merge(input logic [2:0] f3, input logic [1:0] a,
                                              input logic [15:0] d, input logic [31:0] w);
    logic [31:0] m;
    m = w;
    if (f3[0]) m[{a[1], 4'b0000} +: 16] = d;
    else       m[{a, 3'b000} +: 8]      = d[7:0];
    return m;
  endfunction

  always_comb begin
    state_d     = state_q;
    we_d        = we_q;
    funct3_d    = funct3_q;
    alo_d       = alo_q;
    wdata_d     = wdata_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          we_d        = req_we;
          funct3_d    = req_funct3;
          alo_d       = req_addr[1:0];
          wdata_d     = req_wdata[15:0];
          mem_addr_d  = req_addr[N+2:2];
          mem_wdata_d = req_wdata;
          rsp_rdata_d = 32'd0;
          rsp_err_d   = req_bad(req_we, req_funct3, req_addr);
          if (rsp_err_d)                           state_d = RESP;
          else if (req_we && req_funct3 == 3'b010) state_d = WRITE;
          else                                     state_d = ACCESS;
        end
      end
      ACCESS: state_d = DATA;
      // Read word is available here: merge for sub-word stores, format for loads
      DATA: begin
        if (we_q) begin
          mem_wdata_d = store_merge(funct3_q, alo_q, wdata_q, mem_rdata);
          state_d     = WRITE;
        end else begin
          rsp_rdata_d = load_fmt(funct3_q, alo_q, mem_rdata);
          state_d     = RESP;
        end
      end
      WRITE:   state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      mem_addr_q  <= '0;
      mem_wdata_q <= 32'd0;
      rsp_rdata_q <= 32'd0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  // Request context is only meaningful while a request is in flight
  always_ff @(posedge clk) begin
    we_q     <= we_d;
    funct3_q <= funct3_d;
    alo_q    <= alo_d;
    wdata_q  <= wdata_d;
  end

  assign req_ready = (state_q == IDLE) && !reset;
  assign rsp_valid = (state_q == RESP);
  assign mem_we    = (state_q == WRITE);
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_dmem_lsu.sv
// Randomized and directed bench for dmem_lsu with a behavioural memory and reference model.
module tb_dmem_lsu;
  localparam int N = 5;
  localparam int WORDS = 2 ** (N + 1);

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic          req_we = 1'b0;
  logic [2:0]    req_funct3 = 3'd0;
  logic [31:0]   req_addr = 32'd0;
  logic [31:0]   req_wdata = 32'd0;
  logic          rsp_valid;
  logic [31:0]   rsp_rdata;
  logic          rsp_err;
  logic          mem_we;
  logic [N:0]    mem_addr;
  logic [31:0]   mem_wdata;
  logic [31:0]   mem_rdata;

  logic [31:0]   mem [WORDS];
  logic          pre_we = 1'b0;
  logic [N:0]    pre_addr = '0;
  logic [31:0]   pre_data = 32'd0;
  logic [31:0]   ref_mem [WORDS];

  int pass_cnt = 0;
  int total = 0;

  int          obs_lat, obs_wcnt, obs_wk;
  logic [31:0] obs_rdata, obs_wdata;
  logic        obs_err;
  logic [N:0]  obs_waddr;

  dmem_lsu #(.N(N)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_we(req_we), .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (pre_we) mem[pre_addr] <= pre_data;
    else if (mem_we) mem[mem_addr] <= mem_wdata;
    mem_rdata <= mem[mem_addr];
  end

  // Reference: request outcome from the ISA rules, using byte arithmetic on ref_mem
  function automatic void model(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                                input logic [31:0] wd, output logic err, output logic [31:0] rd,
                                output int lat, output logic [31:0] neww);
    int sz, sh;
    logic [31:0] mask, word, loaded;
    sz = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
    err = (we ? (f3 >= 3) : (f3 == 3 || f3 >= 6)) || (addr % sz != 0) || (addr >= 2 ** (N + 3));
    word = ref_mem[(addr >> 2) % WORDS];
    sh = 8 * (addr % 4);
    mask = (sz == 4) ? 32'hFFFF_FFFF : (32'd1 << (8 * sz)) - 1;
    loaded = (word >> sh) & mask;
    if (!f3[2] && sz < 4 && loaded[8 * sz - 1]) loaded = loaded | ~mask;
    rd = (err || we) ? 32'd0 : loaded;
    lat = err ? 1 : we ? ((sz == 4) ? 2 : 4) : 3;
    neww = (word & ~(mask << sh)) | ((wd & mask) << sh);
  endfunction

  task automatic do_req(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wd);
    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wd;
    @(posedge clk); #1;
    req_valid = 1'b0; req_we = 1'($urandom); req_funct3 = 3'($urandom);
    req_addr = $urandom; req_wdata = $urandom;
    obs_lat = -1; obs_wcnt = 0; obs_wk = -1; obs_rdata = 32'hx; obs_err = 1'bx;
    obs_waddr = '0; obs_wdata = 32'd0;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (mem_we) begin obs_wcnt++; obs_wk = k; obs_waddr = mem_addr; obs_wdata = mem_wdata; end
      if (rsp_valid) begin obs_lat = k; obs_rdata = rsp_rdata; obs_err = rsp_err; break; end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    for (int i = 0; i < WORDS; i++) begin
      @(negedge clk);
      pre_we = 1'b1; pre_addr = (N+1)'(i); pre_data = $urandom; ref_mem[i] = pre_data;
    end
    @(negedge clk); pre_we = 1'b0;
    @(negedge clk);
    total++; if (req_ready !== 1'b0) $display("FAIL reset_ready got=%b exp=0", req_ready); else pass_cnt++;
    total++;
    if ({rsp_valid, rsp_err, mem_we} !== 3'b000 || rsp_rdata !== 32'd0 || mem_addr !== '0 || mem_wdata !== 32'd0)
      $display("FAIL reset_outputs got v=%b e=%b we=%b rd=%h a=%h wd=%h exp all 0",
               rsp_valid, rsp_err, mem_we, rsp_rdata, mem_addr, mem_wdata);
    else pass_cnt++;
    reset = 1'b0;
    @(negedge clk);
    total++; if (req_ready !== 1'b1) $display("FAIL reset_release_ready got=%b exp=1", req_ready); else pass_cnt++;
  endtask

  task automatic test_directed();
    logic [2:0]  lf3 [5] = '{3'b000, 3'b100, 3'b001, 3'b101, 3'b010};
    logic [31:0] lad [5] = '{32'h13, 32'h13, 32'h12, 32'h10, 32'h10};
    logic [31:0] lex [5] = '{32'hFFFF_FFDE, 32'h0000_00DE, 32'hFFFF_DEAD, 32'h0000_BEEF, 32'hDEAD_BEEF};
    do_req(1'b1, 3'b010, 32'h10, 32'hDEAD_BEEF);
    ref_mem[4] = 32'hDEAD_BEEF;
    total++;
    if (obs_wcnt !== 1 || obs_wk !== 1 || obs_waddr !== 6'd4 || obs_wdata !== 32'hDEAD_BEEF)
      $display("FAIL sw_write got cnt=%0d k=%0d a=%0d d=%h exp cnt=1 k=1 a=4 d=deadbeef",
               obs_wcnt, obs_wk, obs_waddr, obs_wdata);
    else pass_cnt++;
    total++;
    if (obs_lat !== 2 || obs_err !== 1'b0 || obs_rdata !== 32'd0)
      $display("FAIL sw_rsp got lat=%0d err=%b rd=%h exp lat=2 err=0 rd=0", obs_lat, obs_err, obs_rdata);
    else pass_cnt++;
    for (int i = 0; i < 5; i++) begin
      do_req(1'b0, lf3[i], lad[i], 32'd0);
      total++;
      if (obs_lat !== 3 || obs_err !== 1'b0 || obs_rdata !== lex[i] || obs_wcnt !== 0)
        $display("FAIL load_%0d got lat=%0d err=%b rd=%h we=%0d exp lat=3 err=0 rd=%h we=0",
                 i, obs_lat, obs_err, obs_rdata, obs_wcnt, lex[i]);
      else pass_cnt++;
    end
    do_req(1'b1, 3'b000, 32'h11, 32'h1234_56AA);
    total++;
    if (obs_wcnt !== 1 || obs_wk !== 3 || obs_waddr !== 6'd4 || obs_wdata !== 32'hDEAD_AAEF || obs_lat !== 4)
      $display("FAIL sb got cnt=%0d k=%0d a=%0d d=%h lat=%0d exp cnt=1 k=3 a=4 d=deadaaef lat=4",
               obs_wcnt, obs_wk, obs_waddr, obs_wdata, obs_lat);
    else pass_cnt++;
    do_req(1'b1, 3'b001, 32'h12, 32'h0000_1234);
    total++;
    if (obs_wcnt !== 1 || obs_wk !== 3 || obs_wdata !== 32'h1234_AAEF || obs_lat !== 4 || obs_err !== 1'b0)
      $display("FAIL sh got cnt=%0d k=%0d d=%h lat=%0d err=%b exp cnt=1 k=3 d=1234aaef lat=4 err=0",
               obs_wcnt, obs_wk, obs_wdata, obs_lat, obs_err);
    else pass_cnt++;
    ref_mem[4] = 32'h1234_AAEF;
    do_req(1'b0, 3'b010, 32'h10, 32'd0);
    total++;
    if (obs_rdata !== 32'h1234_AAEF || obs_lat !== 3)
      $display("FAIL lw_confirm got rd=%h lat=%0d exp rd=1234aaef lat=3", obs_rdata, obs_lat);
    else pass_cnt++;
  endtask

  task automatic test_errors();
    logic        ewe [4] = '{1'b0, 1'b1, 1'b0, 1'b0};
    logic [2:0]  ef3 [4] = '{3'b010, 3'b001, 3'b011, 3'b010};
    logic [31:0] ead [4] = '{32'h12, 32'h11, 32'h10, 32'h100};
    for (int i = 0; i < 4; i++) begin
      do_req(ewe[i], ef3[i], ead[i], 32'hFFFF_FFFF);
      total++;
      if (obs_lat !== 1 || obs_err !== 1'b1 || obs_rdata !== 32'd0 || obs_wcnt !== 0)
        $display("FAIL err_%0d got lat=%0d err=%b rd=%h we=%0d exp lat=1 err=1 rd=0 we=0",
                 i, obs_lat, obs_err, obs_rdata, obs_wcnt);
      else pass_cnt++;
    end
  endtask

  task automatic test_random();
    logic        we, e_err;
    logic [2:0]  f3;
    logic [31:0] addr, wd, e_rd, e_new;
    int          e_lat;
    for (int i = 0; i < 60; i++) begin
      we = 1'($urandom);
      f3 = 3'($urandom);
      addr = ($urandom_range(0, 7) == 0) ? $urandom : 32'($urandom_range(0, 2 ** (N + 3) - 1));
      wd = $urandom;
      model(we, f3, addr, wd, e_err, e_rd, e_lat, e_new);
      do_req(we, f3, addr, wd);
      total++;
      if (obs_lat !== e_lat || obs_err !== e_err || obs_rdata !== e_rd)
        $display("FAIL rand_rsp_%0d we=%b f3=%0d a=%h got lat=%0d err=%b rd=%h exp lat=%0d err=%b rd=%h",
                 i, we, f3, addr, obs_lat, obs_err, obs_rdata, e_lat, e_err, e_rd);
      else pass_cnt++;
      total++;
      if (we && !e_err) begin
        if (obs_wcnt !== 1 || obs_waddr !== addr[N+2:2] || obs_wdata !== e_new)
          $display("FAIL rand_wr_%0d got cnt=%0d a=%h d=%h exp cnt=1 a=%h d=%h",
                   i, obs_wcnt, obs_waddr, obs_wdata, addr[N+2:2], e_new);
        else pass_cnt++;
        ref_mem[addr[N+2:2]] = e_new;
      end else begin
        if (obs_wcnt !== 0) $display("FAIL rand_nowr_%0d got cnt=%0d exp 0", i, obs_wcnt);
        else pass_cnt++;
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] addrs [3];
    int          acc_cyc [3];
    logic [31:0] got [$];
    int          idx = 0, cyc = 0, low_in_gap = 0;
    bit          acc;
    for (int i = 0; i < 3; i++) addrs[i] = 32'($urandom_range(0, WORDS - 1)) << 2;
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b010; req_addr = addrs[0];
    while (cyc < 30 && got.size() < 3) begin
      cyc++;
      acc = 1'b0;
      if (rsp_valid) got.push_back(rsp_rdata);
      if (req_ready && req_valid) begin acc_cyc[idx] = cyc; acc = 1'b1; end
      else if (!req_ready && idx > 0) low_in_gap++;
      @(posedge clk); #1;
      if (acc) begin
        idx++;
        if (idx < 3) req_addr = addrs[idx];
        else req_valid = 1'b0;
      end
      @(negedge clk);
    end
    req_valid = 1'b0;
    total++;
    if (idx !== 3 || acc_cyc[1] - acc_cyc[0] !== 4 || acc_cyc[2] - acc_cyc[1] !== 4)
      $display("FAIL b2b_spacing got accepts=%0d at %0d,%0d,%0d exp 3 spaced by 4",
               idx, acc_cyc[0], acc_cyc[1], acc_cyc[2]);
    else pass_cnt++;
    total++;
    if (low_in_gap !== 9) $display("FAIL b2b_ready_low got=%0d exp=9", low_in_gap);
    else pass_cnt++;
    total++;
    if (got.size() !== 3) $display("FAIL b2b_count got=%0d exp=3", got.size());
    else pass_cnt++;
    for (int i = 0; i < 3 && i < got.size(); i++) begin
      total++;
      if (got[i] !== ref_mem[addrs[i][N+2:2]])
        $display("FAIL b2b_data_%0d got=%h exp=%h", i, got[i], ref_mem[addrs[i][N+2:2]]);
      else pass_cnt++;
    end
  endtask

  task automatic test_reset_mid();
    int spurious = 0;
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b000; req_addr = 32'h11; req_wdata = 32'h0000_0055;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(negedge clk);
    if (mem_we || rsp_valid) spurious++;
    @(negedge clk);
    if (mem_we || rsp_valid) spurious++;
    reset = 1'b1;
    @(negedge clk);
    total++;
    if ({rsp_valid, rsp_err, mem_we, req_ready} !== 4'b0000 || rsp_rdata !== 32'd0 ||
        mem_addr !== '0 || mem_wdata !== 32'd0)
      $display("FAIL midreset_outputs got v=%b e=%b we=%b rdy=%b rd=%h a=%h wd=%h exp all 0",
               rsp_valid, rsp_err, mem_we, req_ready, rsp_rdata, mem_addr, mem_wdata);
    else pass_cnt++;
    reset = 1'b0;
    @(negedge clk);
    total++; if (req_ready !== 1'b1) $display("FAIL midreset_ready got=%b exp=1", req_ready); else pass_cnt++;
    for (int i = 0; i < 5; i++) begin
      if (mem_we || rsp_valid) spurious++;
      @(negedge clk);
    end
    total++; if (spurious !== 0) $display("FAIL midreset_spurious got=%0d exp=0", spurious); else pass_cnt++;
    do_req(1'b0, 3'b010, 32'h10, 32'd0);
    total++;
    if (obs_rdata !== ref_mem[4] || obs_lat !== 3)
      $display("FAIL midreset_lw got rd=%h lat=%0d exp rd=%h lat=3", obs_rdata, obs_lat, ref_mem[4]);
    else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_directed();
    test_errors();
    test_random();
    test_back_to_back();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
